execute_stage: RTL and testbench

- Execute stage of the 5-stage RV32I pipeline.
- Consumes ID/EX control and data, applies forwarding, and runs the ALU.
- Drives the branch/jump redirect back to the fetch stage (PCSrcE, PCTargetE), which is the other end of the fetch redirect interface.
- Registers its results into the EX/MEM pipeline register.

---
 rtl/execute_stage_if.sv | 49 ++++
 rtl/execute_stage.sv | 88 ++++++++
 tb/tb_execute_stage.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_if.sv
// ID/EX inputs, fetch redirect and EX/MEM outputs of the RV32I execute stage.
// The slave view belongs to the execute stage; the master view drives it.
interface execute_stage_if #(
  parameter int XLEN = 32,
  parameter int REGW = 5
);
  logic            RegWriteE;
  logic [1:0]      ResultSrcE;
  logic            MemWriteE;
  logic            JumpE;
  logic            BranchE;
  logic [2:0]      ALUControlE;
  logic            ALUSrcE;
  logic [XLEN-1:0] RD1E;
  logic [XLEN-1:0] RD2E;
  logic [XLEN-1:0] ImmExtE;
  logic [REGW-1:0] RdE;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCPlus4E;
  logic [1:0]      ForwardAE;
  logic [1:0]      ForwardBE;
  logic [XLEN-1:0] ResultW;

  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic            RegWriteM;
  logic [1:0]      ResultSrcM;
  logic            MemWriteM;
  logic [XLEN-1:0] ALUResultM;
  logic [XLEN-1:0] WriteDataM;
  logic [REGW-1:0] RdM;
  logic [XLEN-1:0] PCPlus4M;

  modport slave (
    input  RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE,
           ALUSrcE, RD1E, RD2E, ImmExtE, RdE, PCE, PCPlus4E,
           ForwardAE, ForwardBE, ResultW,
    output PCSrcE, PCTargetE, RegWriteM, ResultSrcM, MemWriteM,
           ALUResultM, WriteDataM, RdM, PCPlus4M
  );

  modport master (
    output RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE,
           ALUSrcE, RD1E, RD2E, ImmExtE, RdE, PCE, PCPlus4E,
           ForwardAE, ForwardBE, ResultW,
    input  PCSrcE, PCTargetE, RegWriteM, ResultSrcM, MemWriteM,
           ALUResultM, WriteDataM, RdM, PCPlus4M
  );
endinterface

// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump redirect and the
// EX/MEM pipeline register.
module execute_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input logic            clk,
  input logic            rst,
  execute_stage_if.slave bus
);
  typedef struct packed {
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] pc_plus4;
  } exmem_t;

  exmem_t          exmem_q;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] write_data_int;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic            zero;

  // Forward source 10 is this stage's own registered result (previous instruction).
  always_comb begin
    src_a = bus.RD1E;
    case (bus.ForwardAE)
      2'b01:   src_a = bus.ResultW;
      2'b10:   src_a = exmem_q.alu_result;
      default: src_a = bus.RD1E;
    endcase
  end

  always_comb begin
    write_data_int = bus.RD2E;
    case (bus.ForwardBE)
      2'b01:   write_data_int = bus.ResultW;
      2'b10:   write_data_int = exmem_q.alu_result;
      default: write_data_int = bus.RD2E;
    endcase
  end

  assign src_b = bus.ALUSrcE ? bus.ImmExtE : write_data_int;

  always_comb begin
    alu_result = '0;
    case (bus.ALUControlE)
      3'b000:  alu_result = src_a + src_b;
      3'b001:  alu_result = src_a - src_b;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b100:  alu_result = src_a ^ src_b;
      3'b101:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_result = '0;
    endcase
  end

  assign zero          = (alu_result == '0);
  assign bus.PCTargetE = bus.PCE + bus.ImmExtE;
  // Gated by reset asynchronously so fetch is never redirected while held in reset.
  assign bus.PCSrcE    = rst & ((bus.BranchE & zero) | bus.JumpE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      exmem_q <= '0;
    end else begin
      exmem_q.reg_write  <= bus.RegWriteE;
      exmem_q.result_src <= bus.ResultSrcE;
      exmem_q.mem_write  <= bus.MemWriteE;
      exmem_q.alu_result <= alu_result;
      exmem_q.write_data <= write_data_int;
      exmem_q.rd         <= bus.RdE;
      exmem_q.pc_plus4   <= bus.PCPlus4E;
    end
  end

  assign bus.RegWriteM  = exmem_q.reg_write;
  assign bus.ResultSrcM = exmem_q.result_src;
  assign bus.MemWriteM  = exmem_q.mem_write;
  assign bus.ALUResultM = exmem_q.alu_result;
  assign bus.WriteDataM = exmem_q.write_data;
  assign bus.RdM        = exmem_q.rd;
  assign bus.PCPlus4M   = exmem_q.pc_plus4;
endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: redirect outputs checked in-cycle,
// EX/MEM outputs checked through a scoreboard queue one cycle later.
module tb_execute_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  execute_stage_if #(.XLEN(32), .REGW(5)) bus ();

  execute_stage #(.XLEN(32), .REGW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rw;
    logic [1:0]  rs;
    logic        mw;
    logic        j;
    logic        b;
    logic [2:0]  op;
    logic        srcb;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] resw;
  } ex_in_t;

  typedef struct {
    logic        rw;
    logic [1:0]  rs;
    logic        mw;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] pc4;
  } m_out_t;

  m_out_t sb_q[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic ex_in_t idle();
    ex_in_t i;
    i.rw = 0; i.rs = 2'b00; i.mw = 0; i.j = 0; i.b = 0; i.op = 3'b000; i.srcb = 0;
    i.rd1 = '0; i.rd2 = '0; i.imm = '0; i.rd = '0; i.pc = '0; i.pc4 = '0;
    i.fa = 2'b00; i.fb = 2'b00; i.resw = '0;
    return i;
  endfunction

  task automatic drive(input ex_in_t i);
    bus.RegWriteE   = i.rw;
    bus.ResultSrcE  = i.rs;
    bus.MemWriteE   = i.mw;
    bus.JumpE       = i.j;
    bus.BranchE     = i.b;
    bus.ALUControlE = i.op;
    bus.ALUSrcE     = i.srcb;
    bus.RD1E        = i.rd1;
    bus.RD2E        = i.rd2;
    bus.ImmExtE     = i.imm;
    bus.RdE         = i.rd;
    bus.PCE         = i.pc;
    bus.PCPlus4E    = i.pc4;
    bus.ForwardAE   = i.fa;
    bus.ForwardBE   = i.fb;
    bus.ResultW     = i.resw;
  endtask

  task automatic compare_m(input string tag);
    m_out_t e;
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    check_eq({tag, "_alu"}, bus.ALUResultM, e.alu);
    check_eq({tag, "_wd"},  bus.WriteDataM, e.wd);
    check_eq({tag, "_ctl"}, {27'd0, bus.RegWriteM, bus.ResultSrcM, bus.MemWriteM},
                            {27'd0, e.rw, e.rs, e.mw});
    check_eq({tag, "_rd"},  {27'd0, bus.RdM}, {27'd0, e.rd});
    check_eq({tag, "_pc4"}, bus.PCPlus4M, e.pc4);
  endtask

  // One instruction: drive at negedge, check redirect, push expectation, check after the edge.
  task automatic send(input string tag, input ex_in_t i, input logic [31:0] exp_alu,
                      input logic [31:0] exp_wd, input logic exp_src, input logic [31:0] exp_tgt);
    m_out_t e;
    @(negedge clk);
    drive(i);
    #1;
    check_eq({tag, "_pcsrc"}, {31'd0, bus.PCSrcE}, {31'd0, exp_src});
    check_eq({tag, "_tgt"}, bus.PCTargetE, exp_tgt);
    e.rw = i.rw; e.rs = i.rs; e.mw = i.mw; e.alu = exp_alu; e.wd = exp_wd;
    e.rd = i.rd; e.pc4 = i.pc4;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compare_m(tag);
  endtask

  task automatic check_reset_cycle(input string tag);
    ex_in_t i;
    i = idle();
    i.j = 1; i.rw = 1; i.mw = 1; i.rs = 2'b10; i.b = 1;
    i.rd1 = $urandom; i.rd2 = $urandom; i.imm = $urandom; i.pc = $urandom;
    i.pc4 = $urandom; i.rd = 5'($urandom_range(1, 31));
    @(negedge clk);
    rst = 1'b0;
    drive(i);
    #1;
    check_eq({tag, "_pcsrc"}, {31'd0, bus.PCSrcE}, 32'd0);
    check_eq({tag, "_tgt"}, bus.PCTargetE, i.pc + i.imm);
    @(posedge clk);
    #1;
    check_eq({tag, "_alu"}, bus.ALUResultM, 32'd0);
    check_eq({tag, "_wd"},  bus.WriteDataM, 32'd0);
    check_eq({tag, "_ctl"}, {27'd0, bus.RegWriteM, bus.ResultSrcM, bus.MemWriteM}, 32'd0);
    check_eq({tag, "_rd"},  {27'd0, bus.RdM}, 32'd0);
    check_eq({tag, "_pc4"}, bus.PCPlus4M, 32'd0);
  endtask

  initial begin
    ex_in_t i;
    logic [31:0] sweep_exp [6];
    sweep_exp = '{32'd12, 32'd2, 32'd5, 32'd7, 32'd2, 32'd0};

    drive(idle());
    check_reset_cycle("rst0");
    check_reset_cycle("rst1");
    @(negedge clk);
    rst = 1'b1;

    // First instruction after release is registered normally.
    i = idle(); i.rw = 1; i.rd = 5'd3; i.rd1 = 32'd7; i.rd2 = 32'd5; i.pc4 = 32'h104;
    send("first", i, 32'd12, 32'd5, 1'b0, 32'h0);

    for (int unsigned k = 0; k < 6; k++) begin
      i = idle(); i.rd1 = 32'd7; i.rd2 = 32'd5; i.op = 3'(k); i.rw = 1; i.rd = 5'(k + 1);
      i.pc4 = 32'h200 + 32'(k * 4);
      send($sformatf("sweep%0d", k), i, sweep_exp[k], 32'd5, 1'b0, 32'h0);
    end

    i = idle(); i.op = 3'b101; i.rd1 = 32'hFFFF_FFFF; i.rd2 = 32'd1;
    send("slt_neg", i, 32'd1, 32'd1, 1'b0, 32'h0);
    i = idle(); i.op = 3'b101; i.rd1 = 32'd1; i.rd2 = 32'hFFFF_FFFF;
    send("slt_pos", i, 32'd0, 32'hFFFF_FFFF, 1'b0, 32'h0);

    i = idle(); i.srcb = 1; i.rd1 = 32'h100; i.imm = 32'hFFFF_FFFC; i.rd2 = 32'hDEAD_BEEF;
    i.mw = 1; i.rd = 5'd0;
    send("imm_st", i, 32'h0000_00FC, 32'hDEAD_BEEF, 1'b0, 32'hFFFF_FFFC);

    i = idle(); i.rd1 = 32'd3; i.rd2 = 32'd4; i.rw = 1; i.rd = 5'd5;
    send("fwd_base", i, 32'd7, 32'd4, 1'b0, 32'h0);
    i = idle(); i.fa = 2'b10; i.rd1 = 32'h1234; i.rd2 = 32'd1; i.resw = 32'h99;
    send("fwd_a_m", i, 32'd8, 32'd1, 1'b0, 32'h0);
    i = idle(); i.fb = 2'b01; i.resw = 32'h55; i.rd1 = 32'd0; i.rd2 = 32'hABCD; i.op = 3'b011;
    send("fwd_b_w", i, 32'h55, 32'h55, 1'b0, 32'h0);
    i = idle(); i.fa = 2'b01; i.fb = 2'b10; i.resw = 32'h10; i.rd1 = 32'h7; i.rd2 = 32'h7;
    send("fwd_a_w_b_m", i, 32'h65, 32'h55, 1'b0, 32'h0);
    i = idle(); i.fa = 2'b11; i.fb = 2'b11; i.rd1 = 32'd2; i.rd2 = 32'd3; i.resw = 32'h1000;
    send("fwd_11", i, 32'd5, 32'd3, 1'b0, 32'h0);

    i = idle(); i.b = 1; i.op = 3'b001; i.rd1 = 32'd9; i.rd2 = 32'd9; i.pc = 32'h40;
    i.imm = 32'hFFFF_FFF0;
    send("beq_taken", i, 32'd0, 32'd9, 1'b1, 32'h30);
    i.rd2 = 32'd8;
    send("beq_not", i, 32'd1, 32'd8, 1'b0, 32'h30);

    i = idle(); i.j = 1; i.pc = 32'hFFFF_FFF8; i.imm = 32'h10; i.pc4 = 32'hFFFF_FFFC;
    i.rs = 2'b10; i.rd = 5'd1; i.rw = 1;
    send("jal_wrap", i, 32'd0, 32'd0, 1'b1, 32'h8);

    i = idle(); i.j = 1; i.b = 1; i.op = 3'b000; i.rd1 = 32'd1; i.rd2 = 32'd2;
    i.pc = 32'h1000; i.imm = 32'h24;
    send("br_and_j", i, 32'd3, 32'd2, 1'b1, 32'h1024);

    i = idle(); i.rw = 1; i.rd = 5'd9; i.rd1 = 32'h11; i.rd2 = 32'h22; i.pc4 = 32'h300;
    send("pre_rst", i, 32'h33, 32'h22, 1'b0, 32'h0);
    check_reset_cycle("mid_rst");
    @(negedge clk);
    rst = 1'b1;
    i = idle(); i.rw = 1; i.rd = 5'd4; i.rd1 = 32'h5; i.rd2 = 32'h3; i.op = 3'b100;
    i.pc4 = 32'h404;
    send("post_rst", i, 32'h6, 32'h3, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
